// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - 720p60 timing constants, phase enum and count widths shared with the graphics path
package video_pkg;

    localparam int ACTIVE_H_720P = 1280;
    localparam int FP_H_720P     = 110;
    localparam int SYNC_H_720P   = 40;
    localparam int BP_H_720P     = 220;
    localparam int ACTIVE_V_720P = 720;
    localparam int FP_V_720P     = 5;
    localparam int SYNC_V_720P   = 5;
    localparam int BP_V_720P     = 20;
    localparam int FPS_720P      = 60;

    localparam int H_TOTAL_720P = ACTIVE_H_720P + FP_H_720P + SYNC_H_720P + BP_H_720P;
    localparam int V_TOTAL_720P = ACTIVE_V_720P + FP_V_720P + SYNC_V_720P + BP_V_720P;

    // Width of a counter that spans 0..n-1
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int H_CNT_W = cnt_w(H_TOTAL_720P);
    localparam int V_CNT_W = cnt_w(V_TOTAL_720P);
    localparam int FC_W    = cnt_w(FPS_720P);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

endpackage

// File: rtl/vsg_phase_counter.sv
// rtl/vsg_phase_counter.sv - wrapping position counter with ACTIVE/FRONT/SYNC/BACK phase tracking
module vsg_phase_counter
    import video_pkg::*;
#(
    parameter int TOTAL       = H_TOTAL_720P,
    parameter int FRONT_START = ACTIVE_H_720P,
    parameter int SYNC_START  = ACTIVE_H_720P + FP_H_720P,
    parameter int BACK_START  = ACTIVE_H_720P + FP_H_720P + SYNC_H_720P,
    parameter int W           = cnt_w(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] count,
    output phase_t       phase,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_next;
    phase_t       phase_next;

    assign wrap = advance && (count == LAST);

    // Reset parks at the last position so the first advance lands on 0 / ACTIVE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
            phase <= PH_BACK;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        count_next = count;
        phase_next = phase;
        if (advance) begin
            count_next = wrap ? '0 : count + W'(1);
            case (phase)
                PH_ACTIVE: if (count_next == W'(FRONT_START)) phase_next = PH_FRONT;
                PH_FRONT:  if (count_next == W'(SYNC_START))  phase_next = PH_SYNC;
                PH_SYNC:   if (count_next == W'(BACK_START))  phase_next = PH_BACK;
                PH_BACK:   if (wrap)                          phase_next = PH_ACTIVE;
                default:   phase_next = PH_BACK;
            endcase
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - 720p pixel timing generator; fc_out frame counter present when VSG_FRAME_COUNT_EN is defined
module video_sig_gen
    import video_pkg::*;
#(
    parameter int ACTIVE_H = ACTIVE_H_720P,
    parameter int FP_H     = FP_H_720P,
    parameter int SYNC_H   = SYNC_H_720P,
    parameter int BP_H     = BP_H_720P,
    parameter int ACTIVE_V = ACTIVE_V_720P,
    parameter int FP_V     = FP_V_720P,
    parameter int SYNC_V   = SYNC_V_720P,
    parameter int BP_V     = BP_V_720P,
    parameter int FPS      = FPS_720P
) (
    input  logic                                               clk_pixel_in,
    input  logic                                               rst_n_in,
    output logic [cnt_w(ACTIVE_H + FP_H + SYNC_H + BP_H)-1:0] hcount_out,
    output logic [cnt_w(ACTIVE_V + FP_V + SYNC_V + BP_V)-1:0] vcount_out,
    output logic                                               hs_out,
    output logic                                               vs_out,
    output logic                                               ad_out,
    output logic                                               nf_out
`ifdef VSG_FRAME_COUNT_EN
    ,
    output logic [cnt_w(FPS)-1:0]                              fc_out
`endif
);

    localparam int H_TOTAL = ACTIVE_H + FP_H + SYNC_H + BP_H;
    localparam int V_TOTAL = ACTIVE_V + FP_V + SYNC_V + BP_V;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);

    phase_t h_phase;
    phase_t v_phase;
    logic   h_wrap;
    logic   v_wrap_unused;
    logic   nf_set;

    if (FPS < 2) begin : g_fps_check
        $error("video_sig_gen: FPS must be at least 2");
    end

    vsg_phase_counter #(
        .TOTAL      (H_TOTAL),
        .FRONT_START(ACTIVE_H),
        .SYNC_START (ACTIVE_H + FP_H),
        .BACK_START (ACTIVE_H + FP_H + SYNC_H),
        .W          (HW)
    ) u_h_counter (
        .clk    (clk_pixel_in),
        .rst_n  (rst_n_in),
        .advance(1'b1),
        .count  (hcount_out),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    vsg_phase_counter #(
        .TOTAL      (V_TOTAL),
        .FRONT_START(ACTIVE_V),
        .SYNC_START (ACTIVE_V + FP_V),
        .BACK_START (ACTIVE_V + FP_V + SYNC_V),
        .W          (VW)
    ) u_v_counter (
        .clk    (clk_pixel_in),
        .rst_n  (rst_n_in),
        .advance(h_wrap),
        .count  (vcount_out),
        .phase  (v_phase),
        .wrap   (v_wrap_unused)
    );

    // Flags decode straight from the phase registers, so they track the counts with no skew
    assign hs_out = (h_phase == PH_SYNC);
    assign vs_out = (v_phase == PH_SYNC);
    assign ad_out = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    // Next pixel is (ACTIVE_H, ACTIVE_V): the first blanking pixel after the last visible line
    assign nf_set = (hcount_out == HW'(ACTIVE_H - 1)) && (vcount_out == VW'(ACTIVE_V));

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            nf_out <= 1'b0;
        end else begin
            nf_out <= nf_set;
        end
    end

`ifdef VSG_FRAME_COUNT_EN
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fc_out <= '0;
        end else if (nf_set) begin
            fc_out <= (fc_out == cnt_w(FPS)'(FPS - 1)) ? '0 : fc_out + cnt_w(FPS)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// tb/tb_video_sig_gen.sv - randomized-reset bench for video_sig_gen against an arithmetic timing model
module tb_video_sig_gen;

    typedef struct {
        int ah; int fh; int sh; int bh;
        int av; int fv; int sv; int bv;
        int fps;
    } cfg_t;

    typedef struct {
        int h; int v; int hs; int vs; int ad; int nf; int fc;
    } exp_t;

    localparam cfg_t CD = '{1280, 110, 40, 220, 720, 5, 5, 20, 60};
    localparam cfg_t CS = '{16, 3, 4, 5, 6, 2, 2, 3, 5};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] d_h;
    logic [9:0]  d_v;
    logic        d_hs, d_vs, d_ad, d_nf;
    logic [4:0]  s_h;
    logic [3:0]  s_v;
    logic        s_hs, s_vs, s_ad, s_nf;
`ifdef VSG_FRAME_COUNT_EN
    logic [5:0]  d_fc;
    logic [2:0]  s_fc;
`endif

    video_sig_gen u_dut_d (
        .clk_pixel_in(clk),
        .rst_n_in    (rst_n),
        .hcount_out  (d_h),
        .vcount_out  (d_v),
        .hs_out      (d_hs),
        .vs_out      (d_vs),
        .ad_out      (d_ad),
        .nf_out      (d_nf)
`ifdef VSG_FRAME_COUNT_EN
        ,
        .fc_out      (d_fc)
`endif
    );

    video_sig_gen #(
        .ACTIVE_H(16), .FP_H(3), .SYNC_H(4), .BP_H(5),
        .ACTIVE_V(6),  .FP_V(2), .SYNC_V(2), .BP_V(3),
        .FPS(5)
    ) u_dut_s (
        .clk_pixel_in(clk),
        .rst_n_in    (rst_n),
        .hcount_out  (s_h),
        .vcount_out  (s_v),
        .hs_out      (s_hs),
        .vs_out      (s_vs),
        .ad_out      (s_ad),
        .nf_out      (s_nf)
`ifdef VSG_FRAME_COUNT_EN
        ,
        .fc_out      (s_fc)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs t cycles after the first post-reset edge, from the frame arithmetic alone
    function automatic exp_t model(input cfg_t c, input longint t, input bit running);
        exp_t   e;
        longint ht, vt, frame, off;
        ht    = c.ah + c.fh + c.sh + c.bh;
        vt    = c.av + c.fv + c.sv + c.bv;
        frame = ht * vt;
        off   = longint'(c.av) * ht + c.ah;
        if (!running) begin
            e = '{int'(ht - 1), int'(vt - 1), 0, 0, 0, 0, 0};
            return e;
        end
        e.h  = int'(t % ht);
        e.v  = int'((t / ht) % vt);
        e.hs = (e.h >= c.ah + c.fh && e.h < c.ah + c.fh + c.sh) ? 1 : 0;
        e.vs = (e.v >= c.av + c.fv && e.v < c.av + c.fv + c.sv) ? 1 : 0;
        e.ad = (e.h < c.ah && e.v < c.av) ? 1 : 0;
        e.nf = (t >= off && (t - off) % frame == 0) ? 1 : 0;
        e.fc = (t >= off) ? int'(((t - off) / frame + 1) % c.fps) : 0;
        return e;
    endfunction

    longint t   = 0;
    bit     run = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                run = 1'b1;
                t   = 0;
            end else begin
                t++;
            end
        end
    end

    always @(negedge rst_n) run = 1'b0;

    exp_t   ed, es;
    int     d_hs_len = 0, d_ad_len = 0, s_hs_len = 0, s_ad_len = 0;
    longint s_last_nf = -1;

    always @(negedge clk) begin
        ed = model(CD, t, run && rst_n);
        es = model(CS, t, run && rst_n);
        chk("d_hcount", int'(d_h), ed.h);
        chk("d_vcount", int'(d_v), ed.v);
        chk("d_hs", int'(d_hs), ed.hs);
        chk("d_vs", int'(d_vs), ed.vs);
        chk("d_ad", int'(d_ad), ed.ad);
        chk("d_nf", int'(d_nf), ed.nf);
        chk("s_hcount", int'(s_h), es.h);
        chk("s_vcount", int'(s_v), es.v);
        chk("s_hs", int'(s_hs), es.hs);
        chk("s_vs", int'(s_vs), es.vs);
        chk("s_ad", int'(s_ad), es.ad);
        chk("s_nf", int'(s_nf), es.nf);
`ifdef VSG_FRAME_COUNT_EN
        chk("d_fc", int'(d_fc), ed.fc);
        chk("s_fc", int'(s_fc), es.fc);
`endif
        if (!rst_n) begin
            d_hs_len = 0; d_ad_len = 0; s_hs_len = 0; s_ad_len = 0;
            s_last_nf = -1;
        end else begin
            if (d_hs) d_hs_len++; else if (d_hs_len > 0) begin chk("d_hs_width", d_hs_len, 40); d_hs_len = 0; end
            if (d_ad) d_ad_len++; else if (d_ad_len > 0) begin chk("d_ad_width", d_ad_len, 1280); d_ad_len = 0; end
            if (s_hs) s_hs_len++; else if (s_hs_len > 0) begin chk("s_hs_width", s_hs_len, 4); s_hs_len = 0; end
            if (s_ad) s_ad_len++; else if (s_ad_len > 0) begin chk("s_ad_width", s_ad_len, 16); s_ad_len = 0; end
            if (s_nf) begin
                if (s_last_nf >= 0) chk("s_nf_period", int'(t - s_last_nf), 364);
                s_last_nf = t;
            end
        end
    end

    task automatic chk_reset_literals();
        chk("rst_d_hcount", int'(d_h), 1649);
        chk("rst_d_vcount", int'(d_v), 749);
        chk("rst_d_flags", int'({d_hs, d_vs, d_ad, d_nf}), 0);
        chk("rst_s_hcount", int'(s_h), 27);
        chk("rst_s_vcount", int'(s_v), 12);
        chk("rst_s_flags", int'({s_hs, s_vs, s_ad, s_nf}), 0);
`ifdef VSG_FRAME_COUNT_EN
        chk("rst_fc", int'({d_fc, s_fc}), 0);
`endif
    endtask

    exp_t pm;

    initial begin
        pm = model(CD, 1389, 1'b1);          chk("model_hs_before", pm.hs, 0);
        pm = model(CD, 1390, 1'b1);          chk("model_hs_start", pm.hs, 1);
        pm = model(CD, 1650, 1'b1);          chk("model_line_wrap", pm.h * 1000 + pm.v, 1);
        pm = model(CD, 1237499, 1'b1);       chk("model_frame_end", pm.h * 1000 + pm.v, 1649749);
        pm = model(CD, 1189280, 1'b1);       chk("model_nf", pm.nf * 100 + pm.fc, 101);
        pm = model(CD, 1189280 + 1237500, 1'b1); chk("model_nf2", pm.nf * 100 + pm.fc, 102);
        pm = model(CD, 9025 * 1650, 1'b1);   chk("model_vs_end", pm.vs, 0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_literals();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_d_hcount", int'(d_h), 0);
        chk("first_d_vcount", int'(d_v), 0);
        chk("first_d_ad", int'(d_ad), 1);
        repeat (4000) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1500, 50)) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 chk_reset_literals();
            repeat ($urandom_range(3, 1)) @(negedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (2000) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
